hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core (F/D/E/M/W).
- Sequences the fetch, decode, execute, memory and writeback pipeline registers with per-stage stall and flush enables.
- Resolves operand forwarding into Execute, and interlocks a multi-cycle data memory through a wait-state FSM.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- TIMEOUT, 64, max consecutive MEMWAIT cycles before MemFault is raised (≥2)
- CNTW, 16, width of perf counters

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- RA1D  in  4  decode source reg 1
- RA2D  in  4  decode source reg 2
- RA1E  in  4  execute source reg 1
- RA2E  in  4  execute source reg 2
- WA3E  in  4  execute dest reg
- WA3M  in  4  memory dest reg
- WA3W  in  4  writeback dest reg
- RegWriteE  in  1  execute-stage register-write control
- RegWriteM  in  1  memory-stage register-write control
- RegWriteW  in  1  writeback-stage register-write control
- MemtoRegE  in  1  instr in E is a load
- PCSrcE  in  1  taken branch/PC write resolved in E
- MemReqM  in  1  M-stage instr accesses data memory
- MemReadyM  in  1  data memory completes access this cycle
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- StallE  out  1  hold ID/EX register
- StallM  out  1  hold EX/MEM register
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register
- FlushW  out  1  insert bubble into MEM/WB register
- ForwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  SrcB select, same encoding
- MemFault  out  1  sticky memory timeout flag
- StallCnt  out  CNTW  cycles with StallF=1
- FlushCnt  out  CNTW  cycles with FlushE=1

Behaviour:
- Reset (reset_n low, async):
  - state=RUN, wait counter=0, MemFault=0, StallCnt=FlushCnt=0.
  - All stall/flush outputs 0 and ForwardAE/BE=00 while in reset.
- FSM states: RUN, MEMWAIT.
  - RUN→MEMWAIT when MemReqM=1 and MemReadyM=0.
  - MEMWAIT→RUN on the first cycle MemReadyM=1.
  - Otherwise hold state.
- Forwarding (combinational, every state):
  - ForwardAE=10 if RegWriteM and WA3M==RA1E.
  - Else ForwardAE=01 if RegWriteW and WA3W==RA1E.
  - Else ForwardAE=00.
  - ForwardBE identical with RA2E.
  - M has priority over W. No R15 exclusion.
- Memory wait (state MEMWAIT, or RUN with MemReqM=1 and MemReadyM=0):
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - Overrides load-use and branch terms; PCSrcE is held in E and takes effect after release.
  - The cycle MemReadyM=1 arrives: no memory stall. Outputs follow RUN rules in that same cycle (zero-cycle release).
- Load-use, RUN only:
  - ldStall = MemtoRegE and RegWriteE and (WA3E==RA1D or WA3E==RA2D).
  - Gives StallF=StallD=1 and FlushE=1.
- Branch, RUN only: PCSrcE gives FlushD=1 and FlushE=1.
  - When PCSrcE and ldStall coincide, the branch wins: StallF=StallD=0, FlushD=FlushE=1. The stalled D instruction is on the wrong path.
- Wait counter:
  - Increments each MEMWAIT cycle; clears on exit.
  - On reaching TIMEOUT, MemFault sets and stays 1 until reset.
  - The counter saturates there. The stall continues; no forced release.
- Perf counters:
  - Sampled on posedge; increment when the respective output is 1.
  - Saturate at all-ones; no wrap.
- All state transitions occur on posedge clk. Outputs are combinational from registered state plus current inputs.

Decomposition:
- Shared package core_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - hz_state_t enum (RUN, MEMWAIT).
  - REG_PC=4'd15 constant.
- One sub-module sat_counter (parameter W; inputs clk, reset_n, inc; output count), instantiated twice for the perf counters.

Test Plan:
- RAW forward: RegWriteM=1, WA3M=3, RA1E=3, RegWriteW=1, WA3W=3 -> ForwardAE=10 (M priority). Drop RegWriteM -> ForwardAE=01.
- Load-use: MemtoRegE=RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for exactly that cycle; StallCnt and FlushCnt +1.
- Branch vs load-use: same as above plus PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF/D/E/M=FlushW=1 on 3 cycles, all 0 on the ready cycle; StallCnt=3.
- Timeout: TIMEOUT=4, MemReadyM held 0 for 10 cycles -> MemFault=1 from the 4th MEMWAIT cycle. It remains 1 after ready returns; cleared only by reset_n low.
- Async reset mid-MEMWAIT: drop reset_n between clock edges -> all stalls 0 and counters 0 immediately; state RUN after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and helpers for the five-stage core.
// Forwarding selects, hazard FSM states and register constants.
package core_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_t;

  localparam logic [3:0] REG_PC = 4'd15;

  // Memory stage wins over writeback: it holds the younger result.
  function automatic fwd_sel_t fwd_pick(
    input logic       wr_m,
    input logic [3:0] wa_m,
    input logic       wr_w,
    input logic [3:0] wa_w,
    input logic [3:0] ra
  );
    if (wr_m && (wa_m == ra)) return FWD_M;
    if (wr_w && (wa_w == ra)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter used for debug statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding,
// data-memory wait interlock and debug event counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [3:0]      RA1D,
  input  logic [3:0]      RA2D,
  input  logic [3:0]      RA1E,
  input  logic [3:0]      RA2E,
  input  logic [3:0]      WA3E,
  input  logic [3:0]      WA3M,
  input  logic [3:0]      WA3W,
  input  logic            RegWriteE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            MemtoRegE,
  input  logic            PCSrcE,
  input  logic            MemReqM,
  input  logic            MemReadyM,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushW,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            MemFault,
  output logic [CNTW-1:0] StallCnt,
  output logic [CNTW-1:0] FlushCnt
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT);

  hz_state_t     state;
  hz_state_t     state_nxt;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_nxt;
  logic          mem_stall;
  logic          ld_stall;
  fwd_sel_t      fwd_a;
  fwd_sel_t      fwd_b;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (MemReqM && !MemReadyM) state_nxt = MEMWAIT;
      MEMWAIT: if (MemReadyM) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Saturates at TIMEOUT; the stall itself is never forced to end.
  always_comb begin
    wcnt_nxt = '0;
    if (state_nxt == MEMWAIT) begin
      wcnt_nxt = (wcnt == WMAX) ? wcnt : wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      wcnt     <= '0;
      MemFault <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if ((state_nxt == MEMWAIT) && (wcnt_nxt == WMAX)) begin
        MemFault <= 1'b1;
      end
    end
  end

  assign mem_stall = !MemReadyM &&
                     ((state == MEMWAIT) || MemReqM);

  assign ld_stall = MemtoRegE && RegWriteE &&
                    ((WA3E == RA1D) || (WA3E == RA2D));

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    priority case (1'b1)
      !reset_n: begin
      end
      mem_stall: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end
      // A taken branch discards the load-use victim in D.
      PCSrcE: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      ld_stall: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign fwd_a = fwd_pick(RegWriteM, WA3M, RegWriteW, WA3W, RA1E);
  assign fwd_b = fwd_pick(RegWriteM, WA3M, RegWriteW, WA3W, RA2E);

  assign ForwardAE = reset_n ? fwd_a : FWD_RF;
  assign ForwardBE = reset_n ? fwd_b : FWD_RF;

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (StallF),
    .count   (StallCnt)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (FlushE),
    .count   (FlushCnt)
  );

endmodule
